rom_stream_reader: RTL and testbench

Read-side controller for the 128x8 ROM macro (`clk0`/`csb0`/`addr0`/`dout0`). It accepts a burst command of start address and length, and drives the ROM chip-select and address one word per cycle. It captures `dout0` at the macro's fixed read latency and presents the words on a valid/ready byte stream with full backpressure. It sits between the ROM macro and any consumer (boot loader, table-lookup engine) that needs sequential ROM contents.

---
 rtl/rom_stream_reader.sv | 173 +++++++++++++++++
 tb/tb_rom_stream_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Burst reader for a synchronous ROM macro with 2-cycle read latency; words leave on a valid/ready byte stream.
// Define ROM_READER_CHECKSUM_EN to add the checksum output (modulo-2^DATA_WIDTH sum of popped words).
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// FETCH | issuing ROM reads while FIFO credit allows
// DRAIN | all reads issued; waiting for the last word to be accepted
module rom_stream_reader #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  abort,
    output logic                  rom_csb0,
    output logic [ADDR_WIDTH-1:0] rom_addr0,
    input  logic [DATA_WIDTH-1:0] rom_dout0,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH:0]   remain;
    logic                  s1_vld, s1_last, s2_vld, s2_last;
    logic [PTR_W:0]        wr_ptr, rd_ptr, occupancy;
    logic [PTR_W+1:0]      credit_used;
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic                  accept, len_zero, issue, abort_hit, drain_done;
    logic                  fifo_wr, fifo_rd, fifo_empty, fifo_full;

    assign occupancy   = wr_ptr - rd_ptr;
    assign fifo_empty  = (occupancy == '0);
    assign fifo_full   = (occupancy == (PTR_W+1)'(FIFO_DEPTH));
    // Every issued read already owns a FIFO slot, so the FIFO cannot overflow.
    assign credit_used = {1'b0, occupancy} + (PTR_W+2)'(s1_vld) + (PTR_W+2)'(s2_vld);
    assign fifo_wr     = s2_vld;
    assign fifo_rd     = m_valid && m_ready;

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_data[rd_ptr[PTR_W-1:0]];
    assign m_last  = !fifo_empty && fifo_last[rd_ptr[PTR_W-1:0]];
    assign busy    = (state != IDLE);

    always_ff @(posedge clk0) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        len_zero   = 1'b0;
        issue      = 1'b0;
        abort_hit  = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_len == '0) begin
                        len_zero = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = IDLE;
                end else if (credit_used < DEPTH_C) begin
                    issue = 1'b1;
                    if (remain == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = IDLE;
                end else if (!s1_vld && !s2_vld && fifo_empty) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            rom_csb0  <= 1'b1;
            rom_addr0 <= '0;
            next_addr <= '0;
            remain    <= '0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s2_vld    <= 1'b0;
            s2_last   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_ready <= (state_nxt == IDLE);
            done      <= abort_hit || drain_done;
            cmd_err   <= len_zero;
            rom_csb0  <= !issue;
            if (issue) rom_addr0 <= next_addr;
            if (accept) begin
                next_addr <= cmd_addr;
                remain    <= cmd_len;
            end else if (issue) begin
                next_addr <= next_addr + 1'b1;
                remain    <= remain - 1'b1;
            end
            if (abort_hit) begin
                s1_vld  <= 1'b0;
                s1_last <= 1'b0;
                s2_vld  <= 1'b0;
                s2_last <= 1'b0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                s1_vld  <= issue;
                s1_last <= issue && (remain == (ADDR_WIDTH+1)'(1));
                s2_vld  <= s1_vld;
                s2_last <= s1_last;
                if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
                if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (fifo_wr) begin
            fifo_data[wr_ptr[PTR_W-1:0]] <= rom_dout0;
            fifo_last[wr_ptr[PTR_W-1:0]] <= s2_last;
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    always_ff @(posedge clk0) begin
        if (!rst_n)       checksum <= '0;
        else if (accept)  checksum <= '0;
        else if (fifo_rd) checksum <= checksum + m_data;
    end
`endif

    a_no_overflow: assert property (@(posedge clk0) disable iff (!rst_n) fifo_wr |-> !fifo_full);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a 2-cycle ROM model holding mem[i] = i ^ 8'h5A.
// Inputs change 1 time unit after posedge; the stream monitor samples on negedge.
module tb_rom_stream_reader;
    localparam int AW = 7;
    localparam int DW = 8;

    logic          clk0 = 1'b0;
    logic          rst_n, cmd_valid, cmd_ready, abort, rom_csb0;
    logic          m_valid, m_last, busy, done, cmd_err;
    logic          m_ready = 1'b1;
    logic [AW-1:0] cmd_addr, rom_addr0;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] rom_dout0 = '0;
    logic [DW-1:0] m_data;
`ifdef ROM_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk0 = ~clk0;

    rom_stream_reader dut (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .rom_csb0  (rom_csb0),
        .rom_addr0 (rom_addr0),
        .rom_dout0 (rom_dout0),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
`ifdef ROM_READER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // ROM macro: samples csb/addr at posedge, data appears after the following negedge
    logic          rom_en_q = 1'b0;
    logic [AW-1:0] rom_a_q  = '0;
    always @(posedge clk0) begin
        rom_en_q <= !rom_csb0;
        rom_a_q  <= rom_addr0;
    end
    always @(negedge clk0) if (rom_en_q) rom_dout0 <= {1'b0, rom_a_q} ^ 8'h5A;

    int cyc = 0;
    always @(posedge clk0) cyc++;

    logic       tog_en  = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;
    logic [1:0] ph      = 2'd0;
    always @(posedge clk0) begin
        #1;
        if (tog_en) begin
            m_ready = rdy_pat[ph];
            ph      = ph + 2'd1;
        end else begin
            m_ready = 1'b1;
        end
    end

    int   data_q[$];
    int   last_q[$];
    int   addr_q[$];
    int   popped, issued, last_cnt, done_cnt, err_cnt, busy_cnt, stab_err, max_out;
    int   acc_cyc, first_v_cyc, last_pop_cyc, done_cyc;
    logic stall_prev;
    logic [DW-1:0] held_d;
    logic held_l;

    always @(negedge clk0) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
            if (!rom_csb0) begin
                issued++;
                addr_q.push_back(int'(rom_addr0));
            end
            if (stall_prev && m_valid && (m_data !== held_d || m_last !== held_l)) stab_err++;
            stall_prev = m_valid && !m_ready;
            held_d     = m_data;
            held_l     = m_last;
            if (m_valid && m_ready) begin
                data_q.push_back(int'(m_data));
                last_q.push_back(int'(m_last));
                popped++;
                if (m_last) begin
                    last_cnt++;
                    last_pop_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cmd_err) err_cnt++;
            if (busy) busy_cnt++;
            if (issued - popped > max_out) max_out = issued - popped;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        data_q.delete();
        last_q.delete();
        addr_q.delete();
        popped = 0; issued = 0; last_cnt = 0; done_cnt = 0; err_cnt = 0;
        busy_cnt = 0; stab_err = 0; max_out = 0;
        acc_cyc = -100; first_v_cyc = -1; last_pop_cyc = -100; done_cyc = -100;
        stall_prev = 1'b0;
    endtask

    task automatic start_cmd(input int a, input int l);
        @(posedge clk0); #1;
        cmd_valid = 1'b1;
        cmd_addr  = a[AW-1:0];
        cmd_len   = l[AW:0];
        @(posedge clk0); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk0);
        repeat (3) @(posedge clk0);
        #1;
    endtask

    task automatic check_stream(input string tag, input int exp_d[$], input int exp_lmask);
        int lmask;
        check({tag, "_count"}, popped, exp_d.size());
        if (popped == exp_d.size()) begin
            lmask = 0;
            for (int i = 0; i < exp_d.size(); i++) begin
                check({tag, "_data"}, data_q[i], exp_d[i]);
                lmask = lmask | (last_q[i] << i);
            end
            check({tag, "_last"}, lmask, exp_lmask);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    int exp_q[$];

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; abort = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk0);
        @(negedge clk0);
        check("rst_csb", rom_csb0, 1);
        check("rst_addr", rom_addr0, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_err", cmd_err, 0);
        @(posedge clk0); #1 rst_n = 1'b1;
        @(posedge clk0);
        @(negedge clk0);
        check("cmd_ready_after_rst", cmd_ready, 1);

        // basic 4-word burst
        clear_mon();
        start_cmd(0, 4);
        wait_done(50);
        exp_q = '{'h5A, 'h5B, 'h58, 'h59};
        check_stream("t1", exp_q, 'b1000);
        check("t1_first_valid_lat", first_v_cyc - acc_cyc, 4);
        check("t1_done_after_pop", done_cyc - last_pop_cyc, 2);
`ifdef ROM_READER_CHECKSUM_EN
        check("t1_checksum", checksum, 'h66);
`endif

        // address wrap 127 -> 0
        clear_mon();
        start_cmd(126, 4);
        wait_done(50);
        exp_q = '{'h24, 'h25, 'h5A, 'h5B};
        check_stream("t2", exp_q, 'b1000);
        check("t2_issued", issued, 4);
        if (addr_q.size() == 4) begin
            check("t2_addr0", addr_q[0], 126);
            check("t2_addr1", addr_q[1], 127);
            check("t2_addr2", addr_q[2], 0);
            check("t2_addr3", addr_q[3], 1);
        end

        // full ROM with consumer pattern 1,0,0,1
        clear_mon();
        tog_en = 1'b1;
        start_cmd(0, 128);
        wait_done(800);
        tog_en = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(i ^ 'h5A);
        check({"t3", "_count"}, popped, 128);
        if (popped == 128) begin
            for (int i = 0; i < 128; i++) check("t3_data", data_q[i], exp_q[i]);
            check("t3_last_on_final", last_q[127], 1);
        end
        check("t3_last_cnt", last_cnt, 1);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_stall_stable", stab_err, 0);
        check("t3_max_outstanding", max_out, 4);

        // zero length is rejected
        clear_mon();
        start_cmd(5, 0);
        repeat (6) @(posedge clk0);
        #1;
        check("t4_err_pulses", err_cnt, 1);
        check("t4_issued", issued, 0);
        check("t4_busy_cycles", busy_cnt, 0);
        check("t4_done", done_cnt, 0);

        // abort two cycles after accept
        clear_mon();
        start_cmd(0, 16);
        @(posedge clk0); #1 abort = 1'b1;
        @(posedge clk0); #1 abort = 1'b0;
        @(negedge clk0);
        check("t5_csb", rom_csb0, 1);
        check("t5_m_valid", m_valid, 0);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        repeat (5) @(posedge clk0);
        #1;
        check("t5_done_cnt", done_cnt, 1);
        check("t5_popped", popped, 0);
        check("t5_last_cnt", last_cnt, 0);
        clear_mon();
        start_cmd(10, 3);
        wait_done(50);
        exp_q = '{'h50, 'h51, 'h56};
        check_stream("t5b", exp_q, 'b100);

        // one-cycle reset in the middle of a burst
        clear_mon();
        start_cmd(0, 16);
        repeat (3) @(posedge clk0);
        #1 rst_n = 1'b0;
        @(posedge clk0); #1 rst_n = 1'b1;
        @(negedge clk0);
        check("t6_csb", rom_csb0, 1);
        check("t6_addr", rom_addr0, 0);
        check("t6_m_valid", m_valid, 0);
        check("t6_m_data", m_data, 0);
        check("t6_m_last", m_last, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        @(posedge clk0);
        @(negedge clk0);
        check("t6_cmd_ready", cmd_ready, 1);
        repeat (4) @(posedge clk0);
        #1;
        check("t6_no_done", done_cnt, 0);
        clear_mon();
        start_cmd(0, 2);
        wait_done(50);
        exp_q = '{'h5A, 'h5B};
        check_stream("t6b", exp_q, 'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
